// File: rtl/mac_sequencer_if.sv
// Bundles the job handshake, the weight/input memory ports and the MAC core
// connections of the MAC sequencer.
interface mac_sequencer_if;
  logic       start;
  logic [3:0] n_len;
  logic [2:0] w_addr;
  logic [7:0] w_data;
  logic [2:0] x_addr;
  logic [7:0] x_data;
  logic [7:0] mac_weight;
  logic [7:0] mac_in;
  logic       mac_reset;
  logic       mac_oe;
  logic [7:0] mac_out;
  logic [7:0] result;
  logic       busy;
  logic       done;

  modport slave (
    input  start, n_len, w_data, x_data, mac_out,
    output w_addr, x_addr, mac_weight, mac_in, mac_reset, mac_oe,
           result, busy, done
  );

  modport master (
    output start, n_len, w_data, x_data, mac_out,
    input  w_addr, x_addr, mac_weight, mac_in, mac_reset, mac_oe,
           result, busy, done
  );
endinterface

// File: rtl/mac_sequencer.sv
// Sequences one MAC job: clear the accumulator, stream len weight/input pairs
// from memory, enable the MAC output once and capture it into result.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start; n_len sampled here only
// S_CLEAR | one-cycle accumulator clear (mac_reset)
// S_FEED  | one pair per cycle, index 0..len-1 on both addresses
// S_OE    | one-cycle MAC output enable; result captured at its end
// S_DONE  | one-cycle done pulse, back to S_IDLE
module mac_sequencer #(
  parameter int MAX_LEN = 8
) (
  input  logic            clk,
  input  logic            reset,
  mac_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_OE,
    S_DONE
  } state_t;

  localparam logic [3:0] MAX_LEN_C = 4'(MAX_LEN);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] len_q, len_d;
  logic [7:0] result_q, result_d;

  logic [3:0] req_len;
  logic       last_pair;

  // Over-length requests saturate to the memory depth.
  assign req_len   = (bus.n_len > MAX_LEN_C) ? MAX_LEN_C : bus.n_len;
  assign last_pair = ({1'b0, idx_q} == (len_q - 4'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= 3'd0;
      len_q    <= 4'd0;
      result_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    len_d          = len_q;
    result_d       = result_q;
    bus.w_addr     = 3'd0;
    bus.x_addr     = 3'd0;
    bus.mac_weight = 8'd0;
    bus.mac_in     = 8'd0;
    bus.mac_reset  = 1'b0;
    bus.mac_oe     = 1'b0;
    bus.busy       = 1'b1;
    bus.done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          idx_d = 3'd0;
          if (req_len == 4'd0) begin
            // Empty job never touches the MAC; it just reports a zero result.
            result_d = 8'd0;
            state_d  = S_DONE;
          end else begin
            len_d   = req_len;
            state_d = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        bus.mac_reset = 1'b1;
        idx_d         = 3'd0;
        state_d       = S_FEED;
      end
      S_FEED: begin
        bus.w_addr     = idx_q;
        bus.x_addr     = idx_q;
        bus.mac_weight = bus.w_data;
        bus.mac_in     = bus.x_data;
        if (last_pair) begin
          idx_d   = 3'd0;
          state_d = S_OE;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_OE: begin
        bus.mac_oe = 1'b1;
        result_d   = bus.mac_out;
        state_d    = S_DONE;
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.result = result_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a behavioural MAC core and
// asynchronous weight/input memories.
module tb_mac_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mac_sequencer_if bus ();

  mac_sequencer #(.MAX_LEN(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] w_mem [8];
  logic [7:0] x_mem [8];
  logic [31:0] acc = 32'd0;

  assign bus.w_data  = w_mem[bus.w_addr];
  assign bus.x_data  = x_mem[bus.x_addr];
  assign bus.mac_out = bus.mac_oe ? acc[7:0] : 8'd0;

  always @(posedge clk)
    acc <= bus.mac_reset ? 32'd0 : acc + 32'(bus.mac_weight) * 32'(bus.mac_in);

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int c0 = 0;
  int mon_rel;
  int n_clr, n_oe, n_done, n_busy;
  int clr_at, oe_at, done_at;
  logic [2:0] wa_log [20];
  logic [2:0] xa_log [20];
  logic [7:0] wt_log [20];
  logic [7:0] in_log [20];
  logic       busy_log [20];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    mon_rel = cyc - c0 + 1;
    if (mon_rel >= 0 && mon_rel < 20) begin
      wa_log[mon_rel]   = bus.w_addr;
      xa_log[mon_rel]   = bus.x_addr;
      wt_log[mon_rel]   = bus.mac_weight;
      in_log[mon_rel]   = bus.mac_in;
      busy_log[mon_rel] = bus.busy;
    end
    if (bus.mac_reset) begin n_clr++; if (clr_at < 0) clr_at = mon_rel; end
    if (bus.mac_oe)    begin n_oe++;  if (oe_at < 0)  oe_at  = mon_rel; end
    if (bus.done)      begin n_done++; if (done_at < 0) done_at = mon_rel; end
    if (bus.busy) n_busy++;
  end

  // Cycle k of the job is the k-th cycle after the edge that samples start.
  task automatic run_job(input int n, input int pa, input int pb,
                         input bit hold, input int rst_at);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.n_len = 4'(n);
    @(posedge clk); #1;
    c0 = cyc;
    n_clr = 0; n_oe = 0; n_done = 0; n_busy = 0;
    clr_at = -1; oe_at = -1; done_at = -1;
    for (int i = 0; i < 20; i++) begin
      wa_log[i] = 3'bx; xa_log[i] = 3'bx; wt_log[i] = 8'bx; in_log[i] = 8'bx;
      busy_log[i] = 1'bx;
    end
    for (int k = 1; k <= 16; k++) begin
      bus.start = hold || (k == pa) || (k == pb);
      reset = (k == rst_at);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done: got=%b want=0", bus.done); end
    total++; if ({bus.mac_reset, bus.mac_oe} !== 2'b00) begin bad++; $display("FAIL rst_mac_ctl: got=%b want=00", {bus.mac_reset, bus.mac_oe}); end
    total++; if ({bus.mac_weight, bus.mac_in} !== 16'd0) begin bad++; $display("FAIL rst_operands: got=%h want=0", {bus.mac_weight, bus.mac_in}); end
    total++; if ({bus.w_addr, bus.x_addr} !== 6'd0) begin bad++; $display("FAIL rst_addr: got=%h want=0", {bus.w_addr, bus.x_addr}); end
    total++; if (bus.result !== 8'd0) begin bad++; $display("FAIL rst_result: got=%0d want=0", bus.result); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_after_busy: got=%b want=0", bus.busy); end
  endtask

  task automatic test_basic;
    w_mem[0] = 8'd3; w_mem[1] = 8'd2; x_mem[0] = 8'd4; x_mem[1] = 8'd2;
    run_job(2, 0, 0, 1'b0, 0);
    total++; if (n_clr !== 1 || clr_at !== 1) begin bad++; $display("FAIL basic_clear: got=%0d@%0d want=1@1", n_clr, clr_at); end
    total++; if (wa_log[2] !== 3'd0 || wa_log[3] !== 3'd1) begin bad++; $display("FAIL basic_waddr: got=%0d,%0d want=0,1", wa_log[2], wa_log[3]); end
    total++; if (xa_log[2] !== 3'd0 || xa_log[3] !== 3'd1) begin bad++; $display("FAIL basic_xaddr: got=%0d,%0d want=0,1", xa_log[2], xa_log[3]); end
    total++; if (wt_log[2] !== 8'd3 || in_log[3] !== 8'd2) begin bad++; $display("FAIL basic_feed: got=%0d,%0d want=3,2", wt_log[2], in_log[3]); end
    total++; if (wt_log[1] !== 8'd0 || in_log[4] !== 8'd0 || wa_log[4] !== 3'd0) begin bad++; $display("FAIL basic_idle_zero: got=%0d,%0d,%0d want=0,0,0", wt_log[1], in_log[4], wa_log[4]); end
    total++; if (n_oe !== 1 || oe_at !== 4) begin bad++; $display("FAIL basic_oe: got=%0d@%0d want=1@4", n_oe, oe_at); end
    total++; if (n_done !== 1 || done_at !== 5) begin bad++; $display("FAIL basic_done: got=%0d@%0d want=1@5", n_done, done_at); end
    total++; if (n_busy !== 5) begin bad++; $display("FAIL basic_busy: got=%0d want=5", n_busy); end
    total++; if (bus.result !== 8'd16) begin bad++; $display("FAIL basic_result: got=%0d want=16", bus.result); end
  endtask

  task automatic test_full;
    for (int i = 0; i < 8; i++) begin w_mem[i] = 8'd255; x_mem[i] = 8'd255; end
    run_job(8, 0, 0, 1'b0, 0);
    total++; if (bus.result !== 8'd8) begin bad++; $display("FAIL full_result: got=%0d want=8", bus.result); end
    total++; if (n_busy !== 11) begin bad++; $display("FAIL full_busy: got=%0d want=11", n_busy); end
    total++; if (done_at !== 11 || oe_at !== 10) begin bad++; $display("FAIL full_timing: got=oe%0d done%0d want=oe10 done11", oe_at, done_at); end
    total++; if (wa_log[9] !== 3'd7) begin bad++; $display("FAIL full_last_addr: got=%0d want=7", wa_log[9]); end
  endtask

  task automatic test_zero;
    run_job(0, 0, 0, 1'b0, 0);
    total++; if (n_done !== 1 || done_at !== 1) begin bad++; $display("FAIL zero_done: got=%0d@%0d want=1@1", n_done, done_at); end
    total++; if (n_clr !== 0 || n_oe !== 0) begin bad++; $display("FAIL zero_mac_untouched: got=clr%0d oe%0d want=0,0", n_clr, n_oe); end
    total++; if (bus.result !== 8'd0) begin bad++; $display("FAIL zero_result: got=%0d want=0", bus.result); end
    total++; if (n_busy !== 1) begin bad++; $display("FAIL zero_busy: got=%0d want=1", n_busy); end
  endtask

  task automatic test_over_len;
    for (int i = 0; i < 8; i++) begin w_mem[i] = 8'(i + 1); x_mem[i] = 8'd1; end
    run_job(12, 0, 0, 1'b0, 0);
    total++; if (bus.result !== 8'd36) begin bad++; $display("FAIL over_result: got=%0d want=36", bus.result); end
    total++; if (oe_at !== 10 || done_at !== 11) begin bad++; $display("FAIL over_timing: got=oe%0d done%0d want=oe10 done11", oe_at, done_at); end
  endtask

  task automatic test_busy_start;
    for (int i = 0; i < 4; i++) begin w_mem[i] = 8'(i + 1); x_mem[i] = 8'(i + 5); end
    run_job(4, 3, 7, 1'b0, 0);
    total++; if (n_done !== 1 || done_at !== 7) begin bad++; $display("FAIL busy_start_done: got=%0d@%0d want=1@7", n_done, done_at); end
    total++; if (n_clr !== 1) begin bad++; $display("FAIL busy_start_clear: got=%0d want=1", n_clr); end
    total++; if (busy_log[8] !== 1'b0) begin bad++; $display("FAIL busy_start_idle: got=%b want=0", busy_log[8]); end
    total++; if (bus.result !== 8'd70) begin bad++; $display("FAIL busy_start_result: got=%0d want=70", bus.result); end
  endtask

  task automatic test_back_to_back;
    w_mem[0] = 8'd9; x_mem[0] = 8'd3;
    run_job(1, 0, 0, 1'b1, 0);
    total++; if (n_done !== 3) begin bad++; $display("FAIL b2b_done_cnt: got=%0d want=3", n_done); end
    total++; if (n_clr !== 4) begin bad++; $display("FAIL b2b_clear_cnt: got=%0d want=4", n_clr); end
    total++; if (busy_log[5] !== 1'b0 || busy_log[6] !== 1'b1) begin bad++; $display("FAIL b2b_gap: got=%b%b want=01", busy_log[5], busy_log[6]); end
    total++; if (bus.result !== 8'd27) begin bad++; $display("FAIL b2b_result: got=%0d want=27", bus.result); end
    repeat (10) @(posedge clk);
  endtask

  task automatic test_reset_abort;
    for (int i = 0; i < 4; i++) begin w_mem[i] = 8'(i + 1); x_mem[i] = 8'(i + 5); end
    run_job(4, 0, 0, 1'b0, 3);
    total++; if (n_done !== 0 || n_oe !== 0) begin bad++; $display("FAIL abort_no_done: got=done%0d oe%0d want=0,0", n_done, n_oe); end
    total++; if (busy_log[4] !== 1'b0) begin bad++; $display("FAIL abort_idle: got=%b want=0", busy_log[4]); end
    total++; if (wt_log[4] !== 8'd0 || wa_log[4] !== 3'd0) begin bad++; $display("FAIL abort_outputs: got=%0d,%0d want=0,0", wt_log[4], wa_log[4]); end
    total++; if (bus.result !== 8'd0) begin bad++; $display("FAIL abort_result: got=%0d want=0", bus.result); end
    w_mem[0] = 8'd5; x_mem[0] = 8'd7;
    run_job(1, 0, 0, 1'b0, 0);
    total++; if (n_clr !== 1 || done_at !== 4) begin bad++; $display("FAIL abort_next_seq: got=clr%0d done@%0d want=1,4", n_clr, done_at); end
    total++; if (bus.result !== 8'd35) begin bad++; $display("FAIL abort_next_result: got=%0d want=35", bus.result); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.n_len = 4'd0;
    for (int i = 0; i < 8; i++) begin w_mem[i] = 8'd0; x_mem[i] = 8'd0; end
    test_reset();
    test_basic();
    test_full();
    test_zero();
    test_over_len();
    test_busy_start();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, meaning maximum number of weight/input pairs per job (address width 3).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  job request, sampled in IDLE only.
REQ-005 n_len  input  4  pair count for job, sampled with start; valid 1..8.
REQ-006 w_addr  output  3  weight memory address; memory read is asynchronous.
REQ-007 w_data  input  8  weight read data for w_addr, same cycle.
REQ-008 x_addr  output  3  input-vector memory address; always equal to w_addr.
REQ-009 x_data  input  8  input read data for x_addr, same cycle.
REQ-010 mac_weight  output  8  weight driven to MAC core.
REQ-011 mac_in  output  8  operand driven to MAC core.
REQ-012 mac_reset  output  1  MAC accumulator clear.
REQ-013 mac_oe  output  1  MAC output enable.
REQ-014 mac_out  input  8  MAC core result.
REQ-015 result  output  8  registered captured MAC result, held until next capture or reset.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  single-cycle completion pulse.

Function
REQ-018 SHALL implement FSM states IDLE, CLEAR, FEED, OE, DONE.
REQ-019 IDLE: start=1 and n_len in 1..8 -> CLEAR; latch n_len into len register; index <= 0.
REQ-020 IDLE: start=1 and n_len=0 -> DONE directly; result <= 0; MAC untouched.
REQ-021 IDLE: start=1 and n_len>8 -> treated as 8.
REQ-022 CLEAR: mac_reset=1 for exactly one cycle; -> FEED.
REQ-023 FEED: mac_weight=w_data, mac_in=x_data, w_addr=x_addr=index; index increments each cycle; after len FEED cycles (index=len-1) -> OE.
REQ-024 Outside FEED, mac_weight and mac_in SHALL be 0, so a free-running MAC adds nothing.
REQ-025 Outside FEED, w_addr/x_addr SHALL be 0.
REQ-026 OE: mac_oe=1 for exactly one cycle; result <= mac_out at the end of that cycle; -> DONE.
REQ-027 DONE: done=1 for one cycle; -> IDLE.
REQ-028 Latency: start accepted at edge E0 -> CLEAR in cycle 1, FEED cycles 2..len+1, OE cycle len+2, done high in cycle len+3; busy high cycles 1..len+3.
REQ-029 start while busy SHALL be ignored, not queued; start in the DONE cycle is ignored.
REQ-030 start held high continuously SHALL launch a new job on each return to IDLE.
REQ-031 mac_reset, mac_oe, mac_weight, mac_in and done SHALL be decoded from state/index; only result is registered data.
REQ-032 result SHALL be exactly 8 bits of mac_out; no extension or saturation in this block.

Reset
REQ-033 reset=1 at a clock edge -> state IDLE, index 0, len 0, result 0, from any state including mid-FEED.
REQ-034 While in reset and the cycle after: busy=0, done=0, mac_reset=0, mac_oe=0, mac_weight=0, mac_in=0, addresses 0.
REQ-035 A job aborted by reset SHALL NOT produce done or update result; the next job's CLEAR re-clears the MAC.

Verification
Bench MAC model: per clock, acc <= mac_reset ? 0 : acc + mac_weight*mac_in; mac_out = mac_oe ? acc[7:0] : 0.
REQ-036 n_len=2, w={3,2}, x={4,2}, start pulse -> one mac_reset cycle, FEED addr 0,1, mac_oe at cycle 4, done at cycle 5, result=16.
REQ-037 n_len=8, all w=x=255 -> 8*65025 mod 256, result=8; busy high exactly 11 cycles.
REQ-038 n_len=0, start -> done the next cycle, result=0, no mac_reset or mac_oe pulses.
REQ-039 start re-pulsed during FEED of a 4-pair job -> ignored; exactly one done; result matches the first job.
REQ-040 reset asserted in the 2nd FEED cycle of a 4-pair job -> IDLE next cycle, result=0, no done; a following job n_len=1, w=5, x=7 -> result=35.
